cordic_bin_scheduler: RTL and testbench

CORDIC_BIN_SCHEDULER -- requirements
Module: cordic_bin_scheduler

---
 rtl/cordic_bin_scheduler.sv | 161 ++++++++++++++++
 tb/tb_cordic_bin_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_bin_scheduler.sv
// cordic_bin_scheduler
//   Collects FFT bins from two requesters into per-requester FIFOs and feeds
//   them one at a time to a shared CORDIC engine, alternating between the
//   requesters when both have work. Bins with index >= 16 are counted and
//   discarded. A stalled engine is abandoned after TIMEOUT cycles.
//
// Ports
//   clk_cal, rst           calculation clock, synchronous active-high reset
//   reqK_valid/data/bin    requester K offers {real[31:16], imag[15:0]} + bin
//   reqK_ready             requester K FIFO has room
//   eng_start              one-cycle launch pulse to the engine
//   eng_data, eng_bin      engine operand, held between launches
//   eng_done               engine finished the outstanding conversion
//   done_valid, done_src   completion pulse and owning requester
//   drop_cnt               saturating count of discarded high bins
//   err                    sticky engine-timeout flag
module cordic_bin_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_cal,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_bin,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_bin,
  output logic        req1_ready,
  output logic        eng_start,
  output logic [31:0] eng_data,
  output logic [4:0]  eng_bin,
  input  logic        eng_done,
  output logic        done_valid,
  output logic        done_src,
  output logic [7:0]  drop_cnt,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_q, state_d;

  logic [1:0]    in_valid, ready, push, drop, pop, not_empty;
  logic [31:0]   in_data [2];
  logic [4:0]    in_bin  [2];
  // Stored bins are always < 16, so only the low four index bits are kept.
  logic [35:0]   mem     [2][DEPTH];
  logic [35:0]   head    [2];
  logic [AW-1:0] wr_ptr  [2];
  logic [AW-1:0] rd_ptr  [2];
  logic [CW-1:0] count   [2];

  logic          grant_q, last_grant_q, sel;
  logic [TW-1:0] timer_q;
  logic          timeout;
  logic [8:0]    drop_sum;

  always_comb begin
    in_valid   = {req1_valid, req0_valid};
    in_data[0] = req0_data;
    in_data[1] = req1_data;
    in_bin[0]  = req0_bin;
    in_bin[1]  = req1_bin;
    for (int unsigned k = 0; k < 2; k++) begin
      ready[k]     = (count[k] != FULL_CNT);
      push[k]      = in_valid[k] & ready[k] & ~in_bin[k][4];
      drop[k]      = in_valid[k] & ready[k] &  in_bin[k][4];
      not_empty[k] = (count[k] != '0);
      head[k]      = mem[k][rd_ptr[k]];
    end
    pop = (state_q == ISSUE) ? {grant_q, ~grant_q} : 2'b00;
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // Round-robin: a lone non-empty FIFO wins; on a tie the one not served last.
  assign sel = not_empty[0] ? (not_empty[1] ? ~last_grant_q : 1'b0) : 1'b1;

  assign timeout    = (state_q == WAIT) && !eng_done && (timer_q == TMO_LAST);
  assign eng_start  = (state_q == ISSUE);
  assign done_valid = (state_q == WAIT) && eng_done;
  assign done_src   = grant_q;

  always_ff @(posedge clk_cal) begin
    for (int unsigned k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= {in_bin[k][3:0], in_data[k]};
    end
  end

  always_ff @(posedge clk_cal) begin
    for (int unsigned k = 0; k < 2; k++) begin
      if (rst) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end else begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk_cal) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|not_empty) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (eng_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt} + {8'd0, drop[0]} + {8'd0, drop[1]};
  end

  // The operand is captured at grant time: the head cannot change before the
  // ISSUE cycle pops it, and the register then holds it between launches.
  always_ff @(posedge clk_cal) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      eng_data     <= '0;
      eng_bin      <= '0;
      timer_q      <= '0;
      err          <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (state_q == IDLE && |not_empty) begin
        grant_q  <= sel;
        eng_data <= head[sel][31:0];
        eng_bin  <= {1'b0, head[sel][35:32]};
      end
      if (state_q == ISSUE) last_grant_q <= grant_q;
      if (state_q == WAIT && !eng_done && !timeout) timer_q <= timer_q + TW'(1);
      else                                          timer_q <= '0;
      if (timeout) err <= 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_cordic_bin_scheduler.sv
// Scoreboard bench for cordic_bin_scheduler: stimulus pushes expected engine
// launches and completions into queues; a monitor pops and compares them
// whenever eng_start or done_valid is seen.
module tb_cordic_bin_scheduler;

  logic        clk_cal = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [4:0]  req0_bin = '0, req1_bin = '0;
  logic        req0_ready, req1_ready;
  logic        eng_start, eng_done, done_valid, done_src, err;
  logic [31:0] eng_data;
  logic [4:0]  eng_bin;
  logic [7:0]  drop_cnt;
  logic        auto_done = 1'b0, man_done = 1'b0;

  assign eng_done = auto_done | man_done;

  cordic_bin_scheduler #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk_cal(clk_cal), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_bin(req0_bin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_bin(req1_bin), .req1_ready(req1_ready),
    .eng_start(eng_start), .eng_data(eng_data), .eng_bin(eng_bin), .eng_done(eng_done),
    .done_valid(done_valid), .done_src(done_src), .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk_cal = ~clk_cal;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  bin;
  } issue_t;

  issue_t exp_issue[$];
  logic   exp_done[$];
  int     n_checks = 0;
  int     n_pass = 0;
  bit     auto_en = 1'b0;
  int     eng_delay = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name, input int cycles);
    n_checks++;
    $display("FAIL %s: no response within %0d cycles", name, cycles);
  endtask

  // Monitor: every launch and completion must match the next expectation.
  issue_t mon_e;
  logic   mon_s;
  initial forever begin
    @(negedge clk_cal);
    if (eng_start) begin
      if (exp_issue.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: got data %0h bin %0d, expected none", eng_data, eng_bin);
      end else begin
        mon_e = exp_issue.pop_front();
        check("issue", 64'({eng_data, eng_bin}), 64'(mon_e));
      end
    end
    if (done_valid) begin
      if (exp_done.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done_src %0d, expected no done_valid", done_src);
      end else begin
        mon_s = exp_done.pop_front();
        check("done_src", 64'(done_src), 64'(mon_s));
      end
    end
  end

  // Engine model: in auto mode, answers each launch after eng_delay cycles.
  initial forever begin
    @(negedge clk_cal);
    if (eng_start && auto_en) begin
      repeat (eng_delay) @(posedge clk_cal);
      #1 auto_done = 1'b1;
      @(posedge clk_cal);
      #1 auto_done = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_cal);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    man_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_cal);
      seen = eng_start;
    end
    if (!seen) fail_bound(name, 20);
  endtask

  task automatic drain(input string name);
    bit empty = 1'b0;
    for (int i = 0; i < 300 && !empty; i++) begin
      @(negedge clk_cal);
      empty = (exp_issue.size() == 0) && (exp_done.size() == 0);
    end
    if (!empty) fail_bound(name, 300);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_eng_start"},  64'(eng_start),  64'(0));
    check({tag, "_eng_data"},   64'(eng_data),   64'(0));
    check({tag, "_eng_bin"},    64'(eng_bin),    64'(0));
    check({tag, "_done_valid"}, 64'(done_valid), 64'(0));
    check({tag, "_done_src"},   64'(done_src),   64'(0));
    check({tag, "_drop_cnt"},   64'(drop_cnt),   64'(0));
    check({tag, "_err"},        64'(err),        64'(0));
    check({tag, "_ready0"},     64'(req0_ready), 64'(1));
    check({tag, "_ready1"},     64'(req1_ready), 64'(1));
  endtask

  logic [4:0] t4_bins [3] = '{5'd16, 5'd31, 5'd5};

  initial begin
    // Reset values
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk_cal);
    check_reset_vals("rst");
    tick();

    // Single bin: launch two cycles after the push, completion 10 cycles later
    auto_en = 1'b1;
    eng_delay = 10;
    exp_issue.push_back('{data: 32'h0100_FF00, bin: 5'd3});
    exp_done.push_back(1'b0);
    req0_valid = 1'b1;
    req0_data = 32'h0100_FF00;
    req0_bin = 5'd3;
    tick();
    req0_valid = 1'b0;
    @(negedge clk_cal);
    check("lat_idle", 64'(eng_start), 64'(0));
    @(negedge clk_cal);
    check("lat_issue", 64'(eng_start), 64'(1));
    drain("t1_drain");

    // Round-robin with three bins per requester
    do_reset();
    auto_en = 1'b1;
    eng_delay = 1;
    for (int i = 0; i < 3; i++) begin
      exp_issue.push_back('{data: 32'hA000_0000 + i, bin: 5'(i + 1)});
      exp_issue.push_back('{data: 32'hB000_0000 + i, bin: 5'(i + 8)});
      exp_done.push_back(1'b0);
      exp_done.push_back(1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1;
      req0_data = 32'hA000_0000 + i;
      req0_bin = 5'(i + 1);
      req1_valid = 1'b1;
      req1_data = 32'hB000_0000 + i;
      req1_bin = 5'(i + 8);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("t2_drain");

    // Backpressure with the engine stalled
    do_reset();
    auto_en = 1'b0;
    exp_issue.push_back('{data: 32'hAAAA_0001, bin: 5'd1});
    exp_done.push_back(1'b0);
    exp_issue.push_back('{data: 32'hC000_0000, bin: 5'd2});
    req0_valid = 1'b1;
    req0_data = 32'hAAAA_0001;
    req0_bin = 5'd1;
    tick();
    req0_valid = 1'b0;
    wait_start("t3_first_issue");
    tick();
    req0_valid = 1'b1;
    req0_bin = 5'd2;
    for (int i = 0; i < 5; i++) begin
      req0_data = 32'hC000_0000 + i;
      @(negedge clk_cal);
      check("fill_ready", 64'(req0_ready), 64'(i < 4));
      tick();
    end
    req0_valid = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    wait_start("t3_second_issue");
    @(negedge clk_cal);
    check("slot_freed", 64'(req0_ready), 64'(1));
    tick();
    req0_valid = 1'b1;
    req0_data = 32'hC000_0004;
    tick();
    req0_valid = 1'b0;
    @(negedge clk_cal);
    check("refull", 64'(req0_ready), 64'(0));
    tick();

    // High bins dropped, only bin 5 launched; drop counter saturation
    do_reset();
    auto_en = 1'b1;
    eng_delay = 1;
    exp_issue.push_back('{data: 32'h5555_0005, bin: 5'd5});
    exp_done.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1;
      req1_bin = t4_bins[i];
      req1_data = 32'h5555_0000 + 32'(t4_bins[i]);
      tick();
    end
    req1_valid = 1'b0;
    drain("t4_drain");
    check("drop_two", 64'(drop_cnt), 64'(2));
    check("hold_operand", 64'({eng_data, eng_bin}), 64'({32'h5555_0005, 5'd5}));
    man_done = 1'b1;
    @(negedge clk_cal);
    check("idle_done_ignored", 64'(done_valid), 64'(0));
    tick();
    man_done = 1'b0;
    req0_valid = 1'b1;
    req0_bin = 5'd16;
    req1_valid = 1'b1;
    req1_bin = 5'd20;
    repeat (126) tick();
    @(negedge clk_cal);
    check("drop_254", 64'(drop_cnt), 64'(254));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk_cal);
    check("drop_sat", 64'(drop_cnt), 64'(255));
    tick();

    // Engine timeout, then the queued bin is launched
    do_reset();
    auto_en = 1'b0;
    exp_issue.push_back('{data: 32'h7777_0007, bin: 5'd7});
    exp_issue.push_back('{data: 32'h9999_0009, bin: 5'd9});
    exp_done.push_back(1'b1);
    req0_valid = 1'b1;
    req0_data = 32'h7777_0007;
    req0_bin = 5'd7;
    req1_valid = 1'b1;
    req1_data = 32'h9999_0009;
    req1_bin = 5'd9;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_start("t5_first_issue");
    repeat (64) @(negedge clk_cal);
    check("err_before_timeout", 64'(err), 64'(0));
    @(negedge clk_cal);
    check("err_set", 64'(err), 64'(1));
    check("timeout_to_idle", 64'(eng_start), 64'(0));
    wait_start("t5_next_issue");
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    @(negedge clk_cal);
    check("err_sticky", 64'(err), 64'(1));
    drain("t5_drain");

    // Reset during WAIT abandons the conversion
    do_reset();
    auto_en = 1'b0;
    exp_issue.push_back('{data: 32'h1234_5678, bin: 5'd4});
    req0_valid = 1'b1;
    req0_data = 32'h1234_5678;
    req0_bin = 5'd4;
    tick();
    req0_valid = 1'b0;
    wait_start("t6_issue");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_done = 1'b1;
    @(negedge clk_cal);
    check_reset_vals("midwait");
    tick();
    man_done = 1'b0;
    repeat (3) tick();

    check("sb_empty", 64'(exp_issue.size() + exp_done.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
